// File: rtl/trojan_seq_trigger.sv
// trojan_seq_trigger: programmable masked-sequence match trigger.
// Fires trig_out for PULSE_LEN cycles after hit_thresh full sequences.
module trojan_seq_trigger #(
  parameter int DATA_W    = 64,
  parameter int SEQ_LEN   = 4,
  parameter int PULSE_LEN = 2,
  parameter int CNT_W     = 8,
  localparam int IDX_W    = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_vld,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [DATA_W-1:0] cfg_pat,
  input  logic [DATA_W-1:0] cfg_mask,
  input  logic              cfg_strict,
  input  logic              arm,
  input  logic [CNT_W-1:0]  hit_thresh,
  output logic              trig_out,
  output logic              armed,
  output logic [IDX_W-1:0]  seq_pos,
  output logic [CNT_W-1:0]  hit_count
);

  localparam int PC_W = $clog2(PULSE_LEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEEK = 2'd1,
    FIRE = 2'd2
  } state_t;

  state_t            state;
  logic [PC_W-1:0]   pcnt;
  logic [DATA_W-1:0] pat  [SEQ_LEN];
  logic [DATA_W-1:0] mask [SEQ_LEN];

  logic             m_cur;
  logic             m_first;
  logic             last;
  logic [CNT_W-1:0] hc_inc;
  logic [CNT_W-1:0] thr;
  logic             fire;

  // Stage compare: current expected stage and stage 0 (strict restart).
  always_comb begin
    m_cur   = 1'b0;
    m_first = ((data_in ^ pat[0]) & mask[0]) == '0;
    for (int k = 0; k < SEQ_LEN; k++) begin
      if (int'(seq_pos) == k)
        m_cur = ((data_in ^ pat[k]) & mask[k]) == '0;
    end
  end

  // Completion bookkeeping: saturating count and threshold test.
  always_comb begin
    last   = (seq_pos == IDX_W'(SEQ_LEN - 1));
    hc_inc = (&hit_count) ? hit_count : hit_count + 1'b1;
    thr    = (hit_thresh == '0) ? CNT_W'(1) : hit_thresh;
    fire   = (hc_inc >= thr);
  end

  assign armed = (state != IDLE);

  // Stage registers; writable only while idle, out-of-range index dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < SEQ_LEN; k++) begin
        pat[k]  <= '0;
        mask[k] <= '1;
      end
    end else if (cfg_we && state == IDLE) begin
      for (int k = 0; k < SEQ_LEN; k++) begin
        if (int'(cfg_idx) == k) begin
          pat[k]  <= cfg_pat;
          mask[k] <= cfg_mask;
        end
      end
    end
  end

  // Main FSM: sequence tracking, hit counting and pulse timing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pcnt      <= '0;
      trig_out  <= 1'b0;
      seq_pos   <= '0;
      hit_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (arm) begin
            state     <= SEEK;
            seq_pos   <= '0;
            hit_count <= '0;
          end
        end
        SEEK: begin
          if (!arm) begin
            state     <= IDLE;
            seq_pos   <= '0;
            hit_count <= '0;
          end else if (data_vld) begin
            if (m_cur) begin
              if (last) begin
                seq_pos   <= '0;
                hit_count <= hc_inc;
                if (fire) begin
                  state    <= FIRE;
                  pcnt     <= PC_W'(PULSE_LEN);
                  trig_out <= 1'b1;
                end
              end else begin
                seq_pos <= seq_pos + 1'b1;
              end
            end else if (cfg_strict) begin
              if (SEQ_LEN > 1 && m_first)
                seq_pos <= IDX_W'(1);
              else
                seq_pos <= '0;
            end
          end
        end
        FIRE: begin
          if (pcnt == PC_W'(1)) begin
            trig_out  <= 1'b0;
            seq_pos   <= '0;
            hit_count <= '0;
            state     <= arm ? SEEK : IDLE;
          end else begin
            pcnt <= pcnt - 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          trig_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trojan_seq_trigger.sv
// tb_trojan_seq_trigger: directed vectors for trojan_seq_trigger.
// A second instance with SEQ_LEN=3 covers out-of-range config writes.
module tb_trojan_seq_trigger;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] data_in;
  logic        data_vld;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [63:0] cfg_pat;
  logic [63:0] cfg_mask;
  logic        cfg_strict;
  logic        arm;
  logic [7:0]  hit_thresh;
  logic        trig_out;
  logic        armed;
  logic [1:0]  seq_pos;
  logic [7:0]  hit_count;
  logic        trig3;
  logic        armed3;
  logic [1:0]  pos3;
  logic [7:0]  hc3;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [63:0] A  = 64'h0123_4567_89ab_cdef;
  localparam logic [63:0] B  = 64'hfedc_ba98_7654_3210;
  localparam logic [63:0] C  = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D  = 64'h5555_6666_7777_8888;
  localparam logic [63:0] X  = 64'hdead_beef_0000_0000;
  localparam logic [63:0] W  = 64'h5a5a_5a5a_5a5a_5a5a;
  localparam logic [63:0] F1 = 64'hffff_ffff_ffff_ffff;

  trojan_seq_trigger #(
    .DATA_W(64), .SEQ_LEN(4), .PULSE_LEN(2), .CNT_W(8)
  ) u_dut (
    .clk(clk), .rst(rst),
    .data_in(data_in), .data_vld(data_vld),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_pat(cfg_pat), .cfg_mask(cfg_mask),
    .cfg_strict(cfg_strict), .arm(arm),
    .hit_thresh(hit_thresh),
    .trig_out(trig_out), .armed(armed),
    .seq_pos(seq_pos), .hit_count(hit_count)
  );

  trojan_seq_trigger #(
    .DATA_W(64), .SEQ_LEN(3), .PULSE_LEN(2), .CNT_W(8)
  ) u_dut3 (
    .clk(clk), .rst(rst),
    .data_in(data_in), .data_vld(data_vld),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_pat(cfg_pat), .cfg_mask(cfg_mask),
    .cfg_strict(cfg_strict), .arm(arm),
    .hit_thresh(hit_thresh),
    .trig_out(trig3), .armed(armed3),
    .seq_pos(pos3), .hit_count(hc3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [63:0] d);
    data_in  = d;
    data_vld = 1'b1;
    tick();
    data_vld = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] i,
                     input logic [63:0] p,
                     input logic [63:0] m);
    cfg_idx  = i;
    cfg_pat  = p;
    cfg_mask = m;
    cfg_we   = 1'b1;
    tick();
    cfg_we   = 1'b0;
  endtask

  initial begin
    rst = 1'b0; data_in = '0; data_vld = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_pat = '0;
    cfg_mask = '0; cfg_strict = 1'b1; arm = 1'b0;
    hit_thresh = 8'd1;
    tick(); tick();
    check("rst_trig", trig_out, 0);
    check("rst_armed", armed, 0);
    check("rst_pos", seq_pos, 0);
    check("rst_hc", hit_count, 0);
    rst = 1'b1;
    tick();

    // basic sequence A,B,C,D
    cfg(2'd0, A, F1); cfg(2'd1, B, F1);
    cfg(2'd2, C, F1); cfg(2'd3, D, F1);
    arm = 1'b1;
    tick();
    check("t2_armed", armed, 1);
    beat(A); beat(B); beat(C);
    check("t2_pos3", seq_pos, 3);
    check("t2_trig_pre", trig_out, 0);
    beat(D);
    check("t2_trig_n1", trig_out, 1);
    check("t2_hc", hit_count, 1);
    tick();
    check("t2_trig_n2", trig_out, 1);
    tick();
    check("t2_trig_off", trig_out, 0);
    check("t2_seek", armed, 1);
    check("t2_hc_clr", hit_count, 0);

    // strict restart on stage-0 match
    beat(A); beat(B); beat(A);
    check("t3_restart1", seq_pos, 1);
    beat(B); beat(C); beat(D);
    check("t3_fire", trig_out, 1);
    tick(); tick();
    check("t3_off", trig_out, 0);
    beat(A); beat(B); beat(X);
    check("t3_x_pos", seq_pos, 0);
    beat(B); beat(C); beat(D);
    check("t3_nofire", trig_out, 0);
    check("t3_nf_pos", seq_pos, 0);
    check("t3_nf_hc", hit_count, 0);
    // non-strict: mismatches ignored
    cfg_strict = 1'b0;
    beat(A); beat(X);
    check("t3_ns_hold", seq_pos, 1);
    beat(B); beat(X); beat(C); beat(D);
    check("t3_ns_fire", trig_out, 1);
    tick(); tick();
    cfg_strict = 1'b1;

    // threshold 3 with valid gaps
    hit_thresh = 8'd3;
    beat(A); tick(); tick();
    check("t4_gap_pos", seq_pos, 1);
    beat(B); beat(C); beat(D);
    check("t4_hc1", hit_count, 1);
    check("t4_trig1", trig_out, 0);
    beat(A); beat(B); beat(C); beat(D);
    check("t4_hc2", hit_count, 2);
    check("t4_trig2", trig_out, 0);
    beat(A); beat(B); beat(C); beat(D);
    check("t4_hc3", hit_count, 3);
    check("t4_trig3", trig_out, 1);
    tick(); tick();
    check("t4_off", trig_out, 0);
    check("t4_hc_clr", hit_count, 0);

    // wildcard stage 1, thresh 0 acts as 1, cfg ignored in SEEK
    arm = 1'b0;
    tick();
    check("t5_idle", armed, 0);
    cfg(2'd1, X, 64'h0);
    hit_thresh = 8'd0;
    arm = 1'b1;
    tick();
    cfg(2'd0, X, F1);
    beat(A); beat(W); beat(C); beat(D);
    check("t5_wild_fire", trig_out, 1);
    tick(); tick();

    // arm drop in SEEK and in FIRE
    beat(A); beat(B);
    check("t6_pos2", seq_pos, 2);
    arm = 1'b0;
    tick();
    check("t6_idle", armed, 0);
    check("t6_pos0", seq_pos, 0);
    arm = 1'b1;
    tick();
    beat(A); beat(B); beat(C); beat(D);
    arm = 1'b0;
    check("t6_fire", trig_out, 1);
    tick();
    check("t6_full", trig_out, 1);
    tick();
    check("t6_end", trig_out, 0);
    check("t6_armed", armed, 0);

    // async reset mid-pulse, then reset config
    arm = 1'b1;
    tick();
    beat(A); beat(B); beat(C); beat(D);
    check("t1_pre", trig_out, 1);
    rst = 1'b0;
    #1;
    check("t1_async", trig_out, 0);
    check("t1_armed", armed, 0);
    tick();
    rst = 1'b1;
    tick();
    beat(64'h1);
    check("t1_mask_ones", seq_pos, 0);
    beat(0); beat(0); beat(0);
    check("t1_pos3", seq_pos, 3);
    check("t1_nf", trig_out, 0);
    beat(0);
    check("t1_fire", trig_out, 1);

    // out-of-range stage write on the 3-stage instance
    arm = 1'b0;
    tick(); tick(); tick();
    check("t5_d3_idle", armed3, 0);
    cfg(2'd3, F1, F1);
    arm = 1'b1;
    tick();
    beat(0); beat(0); beat(0);
    check("t5_d3_fire", trig3, 1);
    check("t5_d3_hc", hc3, 1);
    check("t5_d3_pos", pos3, 0);
    check("t5_d4_pos", seq_pos, 3);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
